uart_rx_edge_bit_sampler: RTL

Oversampling timing and data-recovery stage of the UART receiver. It sits directly upstream of the receiver control FSM. It counts oversampling edges and bit periods from `Prescale`, takes three majority-voted samples of `RX_IN` around each bit centre, and returns `edge_cnt`, `bit_cnt` and `sampled_bit` to the FSM. The FSM drives its enables.

---
 rtl/uart_rx_edge_bit_sampler.sv | 113 +++++++++++
 1 files changed

// File: rtl/uart_rx_edge_bit_sampler.sv
// Oversampling edge/bit counter and 3-sample majority-vote data recovery for the UART receiver.
// Counters and sampler are enabled by the receiver control FSM; all outputs are registered.
module uart_rx_edge_bit_sampler #(
    parameter int PRESCALE_W = 6,
    parameter int EDGE_W     = 5,
    parameter int BIT_W      = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic [PRESCALE_W-1:0] Prescale,
    input  logic                  edge_cnt_en,
    input  logic                  data_samp_en,
    output logic [EDGE_W-1:0]     edge_cnt,
    output logic [BIT_W-1:0]      bit_cnt,
    output logic                  sampled_bit,
    output logic                  samp_valid,
    output logic                  prescale_err
);

    localparam logic [BIT_W-1:0] BIT_MAX = {BIT_W{1'b1}};

    logic                  prescale_ok;
    logic [PRESCALE_W-1:0] edge_ext;
    logic [PRESCALE_W-1:0] last_edge;
    logic [PRESCALE_W-1:0] mid;
    logic [PRESCALE_W-1:0] mid_m1;
    logic [PRESCALE_W-1:0] mid_p1;

    logic [EDGE_W-1:0]     edge_nxt;
    logic [BIT_W-1:0]      bit_nxt;
    logic                  s0, s1;
    logic                  s0_nxt, s1_nxt;
    logic                  sampled_nxt;
    logic                  valid_nxt;
    logic                  vote;

    assign prescale_ok = (Prescale == PRESCALE_W'(8))  ||
                         (Prescale == PRESCALE_W'(16)) ||
                         (Prescale == PRESCALE_W'(32));

    // Edge count widened to the prescale width so a mid-frame Prescale drop still wraps.
    assign edge_ext  = PRESCALE_W'(edge_cnt);
    assign last_edge = Prescale - PRESCALE_W'(1);

    assign mid    = Prescale >> 1;
    assign mid_m1 = mid - PRESCALE_W'(1);
    assign mid_p1 = mid + PRESCALE_W'(1);

    assign vote = (s0 & s1) | (s0 & RX_IN) | (s1 & RX_IN);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        edge_nxt = edge_cnt;
        bit_nxt  = bit_cnt;
        if (!edge_cnt_en || !prescale_ok) begin
            edge_nxt = '0;
            bit_nxt  = '0;
        end else if (edge_ext >= last_edge) begin
            edge_nxt = '0;
            if (bit_cnt != BIT_MAX) begin
                bit_nxt = bit_cnt + BIT_W'(1);
            end
        end else begin
            edge_nxt = edge_cnt + EDGE_W'(1);
        end
    end

    always_comb begin
        s0_nxt      = s0;
        s1_nxt      = s1;
        sampled_nxt = sampled_bit;
        valid_nxt   = 1'b0;
        if (!data_samp_en) begin
            s0_nxt      = 1'b1;
            s1_nxt      = 1'b1;
            sampled_nxt = 1'b1;
        end else if (edge_cnt_en) begin
            if (edge_ext == mid_m1) begin
                s0_nxt = RX_IN;
            end
            if (edge_ext == mid) begin
                s1_nxt = RX_IN;
            end
            if (edge_ext == mid_p1) begin
                sampled_nxt = vote;
                valid_nxt   = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            edge_cnt     <= '0;
            bit_cnt      <= '0;
            s0           <= 1'b1;
            s1           <= 1'b1;
            sampled_bit  <= 1'b1;
            samp_valid   <= 1'b0;
            prescale_err <= 1'b0;
        end else begin
            edge_cnt     <= edge_nxt;
            bit_cnt      <= bit_nxt;
            s0           <= s0_nxt;
            s1           <= s1_nxt;
            sampled_bit  <= sampled_nxt;
            samp_valid   <= valid_nxt;
            prescale_err <= !prescale_ok;
        end
    end

endmodule
